id_stage_pipe: RTL and testbench

//  Parametrised decode stage with integrated ID/EX pipeline register, between IF/ID and EX.

---
 rtl/id_stage_pipe_pkg.sv | 153 +++++++++++++++
 rtl/id_stage_pipe_id_ex_reg.sv | 117 +++++++++++
 rtl/id_stage_pipe.sv | 193 +++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared constants, decode-control bundle and instruction decoder for the
// ID stage of the logic/shift/LUI/LW pipeline subset.
package id_stage_pipe_pkg;

  // Bus widths
  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int ALUOP_W     = 8;
  localparam int ALUSEL_W    = 3;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;

  // ALU result-select codes
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE = 3'b111;

  // Which immediate an operand port takes when its read is disabled
  typedef enum logic [2:0] {
    IMM_ZERO = 3'd0,
    IMM_SA   = 3'd1,
    IMM_ZEXT = 3'd2,
    IMM_SEXT = 3'd3,
    IMM_LUI  = 3'd4
  } imm_sel_t;

  typedef struct packed {
    logic                  re1;
    logic                  re2;
    imm_sel_t              imm1;
    imm_sel_t              imm2;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic                  illegal;
  } dec_ctrl_t;

  // Decode one instruction into its control bundle; unknown encodings give a
  // NOP bundle with the illegal flag set.
  function automatic dec_ctrl_t decode_inst(input logic [INST_W-1:0] inst);
    dec_ctrl_t d;
    d.re1     = 1'b0;
    d.re2     = 1'b0;
    d.imm1    = IMM_ZERO;
    d.imm2    = IMM_ZERO;
    d.we      = 1'b0;
    d.waddr   = 5'd0;
    d.aluop   = EXE_NOP_OP;
    d.alusel  = EXE_RES_NOP;
    d.illegal = 1'b1;
    case (inst[31:26])
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.re1     = 1'b1;
        d.imm2    = IMM_ZEXT;
        d.we      = 1'b1;
        d.waddr   = inst[20:16];
        d.alusel  = EXE_RES_LOGIC;
        d.illegal = 1'b0;
        case (inst[31:26])
          OP_ANDI: d.aluop = EXE_AND_OP;
          OP_XORI: d.aluop = EXE_XOR_OP;
          default: d.aluop = EXE_OR_OP;
        endcase
      end
      OP_LUI: begin
        d.imm2    = IMM_LUI;
        d.we      = 1'b1;
        d.waddr   = inst[20:16];
        d.aluop   = EXE_OR_OP;
        d.alusel  = EXE_RES_LOGIC;
        d.illegal = 1'b0;
      end
      OP_LW: begin
        d.re1     = 1'b1;
        d.imm2    = IMM_SEXT;
        d.we      = 1'b1;
        d.waddr   = inst[20:16];
        d.aluop   = EXE_LW_OP;
        d.alusel  = EXE_RES_LOAD_STORE;
        d.illegal = 1'b0;
      end
      OP_SPECIAL: begin
        case (inst[5:0])
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            d.re1     = 1'b1;
            d.re2     = 1'b1;
            d.we      = 1'b1;
            d.waddr   = inst[15:11];
            d.alusel  = EXE_RES_LOGIC;
            d.illegal = 1'b0;
            case (inst[5:0])
              FN_AND:  d.aluop = EXE_AND_OP;
              FN_XOR:  d.aluop = EXE_XOR_OP;
              FN_NOR:  d.aluop = EXE_NOR_OP;
              default: d.aluop = EXE_OR_OP;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shift-by-immediate is only defined with rs == 0
            if (inst[25:21] == 5'd0) begin
              d.re2     = 1'b1;
              d.imm1    = IMM_SA;
              d.we      = 1'b1;
              d.waddr   = inst[15:11];
              d.alusel  = EXE_RES_SHIFT;
              d.illegal = 1'b0;
              case (inst[5:0])
                FN_SRL:  d.aluop = EXE_SRL_OP;
                FN_SRA:  d.aluop = EXE_SRA_OP;
                default: d.aluop = EXE_SLL_OP;
              endcase
            end else begin
              d.illegal = 1'b1;
            end
          end
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipe_id_ex_reg.sv
// ID/EX pipeline register: async reset, then flush > hold > bubble > capture.
// The illegal flag is a one-cycle pulse, so it is cleared rather than held.
module id_ex_reg
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   hold_i,
  input  logic                   bubble_i,
  input  logic                   valid_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [ALUOP_W-1:0]     aluop_i,
  input  logic [ALUSEL_W-1:0]    alusel_i,
  input  logic [DATA_W-1:0]      reg1_i,
  input  logic [DATA_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0]  waddr_i,
  input  logic                   we_i,
  input  logic                   illegal_i,
  output logic                   ex_valid_o,
  output logic [INST_ADDR_W-1:0] ex_pc_o,
  output logic [ALUOP_W-1:0]     ex_aluop_o,
  output logic [ALUSEL_W-1:0]    ex_alusel_o,
  output logic [DATA_W-1:0]      ex_reg1_o,
  output logic [DATA_W-1:0]      ex_reg2_o,
  output logic [REG_ADDR_W-1:0]  ex_waddr_o,
  output logic                   ex_we_o,
  output logic                   illegal_o
);

  logic                   valid_q,   valid_d;
  logic [INST_ADDR_W-1:0] pc_q,      pc_d;
  logic [ALUOP_W-1:0]     aluop_q,   aluop_d;
  logic [ALUSEL_W-1:0]    alusel_q,  alusel_d;
  logic [DATA_W-1:0]      reg1_q,    reg1_d;
  logic [DATA_W-1:0]      reg2_q,    reg2_d;
  logic [REG_ADDR_W-1:0]  waddr_q,   waddr_d;
  logic                   we_q,      we_d;
  logic                   illegal_q, illegal_d;

  // Next-state selection: bubble unless holding or capturing a real instruction
  always_comb begin
    valid_d   = 1'b0;
    pc_d      = '0;
    aluop_d   = EXE_NOP_OP;
    alusel_d  = EXE_RES_NOP;
    reg1_d    = '0;
    reg2_d    = '0;
    waddr_d   = 5'd0;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (hold_i) begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      aluop_d  = aluop_q;
      alusel_d = alusel_q;
      reg1_d   = reg1_q;
      reg2_d   = reg2_q;
      waddr_d  = waddr_q;
      we_d     = we_q;
    end else if (bubble_i) begin
      valid_d = 1'b0;
    end else if (valid_i) begin
      valid_d   = 1'b1;
      pc_d      = pc_i;
      aluop_d   = aluop_i;
      alusel_d  = alusel_i;
      reg1_d    = reg1_i;
      reg2_d    = reg2_i;
      waddr_d   = waddr_i;
      we_d      = we_i;
      illegal_d = illegal_i;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      aluop_q   <= EXE_NOP_OP;
      alusel_q  <= EXE_RES_NOP;
      reg1_q    <= '0;
      reg2_q    <= '0;
      waddr_q   <= 5'd0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid_o  = valid_q;
  assign ex_pc_o     = pc_q;
  assign ex_aluop_o  = aluop_q;
  assign ex_alusel_o = alusel_q;
  assign ex_reg1_o   = reg1_q;
  assign ex_reg2_o   = reg2_q;
  assign ex_waddr_o  = waddr_q;
  assign ex_we_o     = we_q;
  assign illegal_o   = illegal_q;

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: instruction decode, regfile read ports, EX/MEM forwarding,
// load-use hazard detection, saturating stall counter, and the ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0]      inst_i,
  input  logic                   inst_valid_i,
  input  logic                   flush_i,
  input  logic                   ex_stall_i,
  output logic                   re1_o,
  output logic                   re2_o,
  output logic [REG_ADDR_W-1:0]  raddr1_o,
  output logic [REG_ADDR_W-1:0]  raddr2_o,
  input  logic [DATA_W-1:0]      rdata1_i,
  input  logic [DATA_W-1:0]      rdata2_i,
  input  logic                   ex_we_i,
  input  logic [REG_ADDR_W-1:0]  ex_waddr_i,
  input  logic [DATA_W-1:0]      ex_wdata_i,
  input  logic                   ex_is_load_i,
  input  logic                   mem_we_i,
  input  logic [REG_ADDR_W-1:0]  mem_waddr_i,
  input  logic [DATA_W-1:0]      mem_wdata_i,
  output logic                   stall_o,
  output logic                   ex_valid_o,
  output logic [INST_ADDR_W-1:0] ex_pc_o,
  output logic [ALUOP_W-1:0]     ex_aluop_o,
  output logic [ALUSEL_W-1:0]    ex_alusel_o,
  output logic [DATA_W-1:0]      ex_reg1_o,
  output logic [DATA_W-1:0]      ex_reg2_o,
  output logic [REG_ADDR_W-1:0]  ex_waddr_o,
  output logic                   ex_we_o,
  output logic                   illegal_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam bit FWD = (FWD_EN != 0);

  dec_ctrl_t          dec_s;
  logic               re1_s, re2_s;
  logic [DATA_W-1:0]  imm1_s, imm2_s;
  logic [DATA_W-1:0]  reg1_s, reg2_s;
  logic               ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s;
  logic               hazard_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Expand the selected immediate to the operand width
  function automatic logic [DATA_W-1:0] imm_val(input imm_sel_t sel, input logic [15:0] imm16);
    logic [DATA_W-1:0] v;
    case (sel)
      IMM_SA: begin
        v      = '0;
        v[4:0] = imm16[10:6];
      end
      IMM_ZEXT: begin
        v       = '0;
        v[15:0] = imm16;
      end
      IMM_SEXT: begin
        v       = {DATA_W{imm16[15]}};
        v[15:0] = imm16;
      end
      IMM_LUI: begin
        v        = '0;
        v[31:16] = imm16;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Operand priority: immediate, $0, EX forward, MEM forward, regfile
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic                  re,
    input logic [REG_ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0]     imm,
    input logic [DATA_W-1:0]     rdata,
    input logic                  ex_hit,
    input logic [DATA_W-1:0]     ex_wdata,
    input logic                  mem_hit,
    input logic [DATA_W-1:0]     mem_wdata
  );
    logic [DATA_W-1:0] v;
    if (!re) begin
      v = imm;
    end else if (raddr == 5'd0) begin
      v = '0;
    end else if (FWD && ex_hit) begin
      v = ex_wdata;
    end else if (FWD && mem_hit) begin
      v = mem_wdata;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Decode, read-port control, forwarding and hazard detection
  always_comb begin
    dec_s    = decode_inst(inst_i);
    re1_s    = inst_valid_i & dec_s.re1;
    re2_s    = inst_valid_i & dec_s.re2;
    imm1_s   = imm_val(dec_s.imm1, inst_i[15:0]);
    imm2_s   = imm_val(dec_s.imm2, inst_i[15:0]);

    ex_hit1_s  = ex_we_i  && (ex_waddr_i  == inst_i[25:21]);
    ex_hit2_s  = ex_we_i  && (ex_waddr_i  == inst_i[20:16]);
    mem_hit1_s = mem_we_i && (mem_waddr_i == inst_i[25:21]);
    mem_hit2_s = mem_we_i && (mem_waddr_i == inst_i[20:16]);

    reg1_s = pick_operand(re1_s, inst_i[25:21], imm1_s, rdata1_i,
                          ex_hit1_s, ex_wdata_i, mem_hit1_s, mem_wdata_i);
    reg2_s = pick_operand(re2_s, inst_i[20:16], imm2_s, rdata2_i,
                          ex_hit2_s, ex_wdata_i, mem_hit2_s, mem_wdata_i);

    // Reads of $0 never create a dependency
    hazard_s = 1'b0;
    if (inst_valid_i) begin
      if (ex_is_load_i && ex_we_i && (ex_waddr_i != 5'd0) &&
          ((re1_s && ex_hit1_s) || (re2_s && ex_hit2_s))) begin
        hazard_s = 1'b1;
      end else if (!FWD &&
          ((re1_s && (inst_i[25:21] != 5'd0) && (ex_hit1_s || mem_hit1_s)) ||
           (re2_s && (inst_i[20:16] != 5'd0) && (ex_hit2_s || mem_hit2_s)))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = 1'b0;
      end
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign re1_o    = re1_s;
  assign re2_o    = re2_s;
  assign raddr1_o = inst_i[25:21];
  assign raddr2_o = inst_i[20:16];
  assign stall_o  = hazard_s | ex_stall_i;

  // Stall counter next value: count unflushed stall edges, saturate at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && !flush_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

  id_ex_reg #(.DATA_W(DATA_W)) u_id_ex_reg (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .hold_i      (ex_stall_i),
    .bubble_i    (hazard_s),
    .valid_i     (inst_valid_i),
    .pc_i        (pc_i),
    .aluop_i     (dec_s.aluop),
    .alusel_i    (dec_s.alusel),
    .reg1_i      (reg1_s),
    .reg2_i      (reg2_s),
    .waddr_i     (dec_s.waddr),
    .we_i        (dec_s.we),
    .illegal_i   (dec_s.illegal),
    .ex_valid_o  (ex_valid_o),
    .ex_pc_o     (ex_pc_o),
    .ex_aluop_o  (ex_aluop_o),
    .ex_alusel_o (ex_alusel_o),
    .ex_reg1_o   (ex_reg1_o),
    .ex_reg2_o   (ex_reg2_o),
    .ex_waddr_o  (ex_waddr_o),
    .ex_we_o     (ex_we_o),
    .illegal_o   (illegal_o)
  );

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a forwarding instance with defaults and a
// non-forwarding instance with a 4-bit stall counter share the same stimulus.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid, flush, ex_stall;
  logic [31:0] rdata1, rdata2;
  logic        ex_we, ex_is_load, mem_we;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;

  logic        re1, re2, stall, ex_valid, ex_we_q, illegal;
  logic [4:0]  raddr1, raddr2, ex_waddr_q;
  logic [31:0] ex_pc, ex_reg1, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [15:0] stall_cnt;

  logic        re1_nf, re2_nf, stall_nf, ex_valid_nf, ex_we_nf, illegal_nf;
  logic [4:0]  raddr1_nf, raddr2_nf, ex_waddr_nf;
  logic [31:0] ex_pc_nf, ex_reg1_nf, ex_reg2_nf;
  logic [7:0]  ex_aluop_nf;
  logic [2:0]  ex_alusel_nf;
  logic [3:0]  stall_cnt_nf;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  id_stage_pipe u_dut (
    .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst), .inst_valid_i(inst_valid),
    .flush_i(flush), .ex_stall_i(ex_stall), .re1_o(re1), .re2_o(re2),
    .raddr1_o(raddr1), .raddr2_o(raddr2), .rdata1_i(rdata1), .rdata2_i(rdata2),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .stall_o(stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_aluop_o(ex_aluop),
    .ex_alusel_o(ex_alusel), .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2),
    .ex_waddr_o(ex_waddr_q), .ex_we_o(ex_we_q), .illegal_o(illegal), .stall_cnt_o(stall_cnt)
  );

  id_stage_pipe #(.DATA_W(32), .FWD_EN(0), .CNT_W(4)) u_dut_nf (
    .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst), .inst_valid_i(inst_valid),
    .flush_i(flush), .ex_stall_i(ex_stall), .re1_o(re1_nf), .re2_o(re2_nf),
    .raddr1_o(raddr1_nf), .raddr2_o(raddr2_nf), .rdata1_i(rdata1), .rdata2_i(rdata2),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .stall_o(stall_nf), .ex_valid_o(ex_valid_nf), .ex_pc_o(ex_pc_nf), .ex_aluop_o(ex_aluop_nf),
    .ex_alusel_o(ex_alusel_nf), .ex_reg1_o(ex_reg1_nf), .ex_reg2_o(ex_reg2_nf),
    .ex_waddr_o(ex_waddr_nf), .ex_we_o(ex_we_nf), .illegal_o(illegal_nf), .stall_cnt_o(stall_cnt_nf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
    mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  waddr;
    logic        we;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"ori",  32'h34011100, 32'h00000000, 32'h00001100, 8'h25, 3'd1, 5'd1, 1'b1};
    vecs[1] = '{"lui",  32'h3C07ABCD, 32'h00000000, 32'hABCD0000, 8'h25, 3'd1, 5'd7, 1'b1};
    vecs[2] = '{"sll",  32'h00031100, 32'h00000004, 32'h0000BEEF, 8'h7C, 3'd2, 5'd2, 1'b1};
    vecs[3] = '{"lw",   32'h8C66FFFC, 32'hCAFE0000, 32'hFFFFFFFC, 8'hE3, 3'd7, 5'd6, 1'b1};
    vecs[4] = '{"or",   32'h00652025, 32'hCAFE0000, 32'h0000BEEF, 8'h25, 3'd1, 5'd4, 1'b1};
    vecs[5] = '{"andi", 32'h306200F0, 32'hCAFE0000, 32'h000000F0, 8'h24, 3'd1, 5'd2, 1'b1};
    vecs[6] = '{"nor",  32'h00652027, 32'hCAFE0000, 32'h0000BEEF, 8'h27, 3'd1, 5'd4, 1'b1};
    vecs[7] = '{"bad",  32'hFC000000, 32'h00000000, 32'h00000000, 8'h00, 3'd0, 5'd0, 1'b0};

    rst = 1'b1; pc = 32'h0; inst = 32'h0; inst_valid = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    rdata1 = 32'hCAFE0000; rdata2 = 32'h0000BEEF;
    clear_wb();
    #3;
    check_eq("rst_valid", ex_valid, 0);
    check_eq("rst_we", ex_we_q, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    check_eq("rst_illegal", illegal, 0);

    @(negedge clk); rst = 1'b0;

    // ori $1,$0,0x1100
    inst = 32'h34011100; inst_valid = 1'b1; pc = 32'h100;
    #1;
    check_eq("t1_re1", re1, 1);
    check_eq("t1_re2", re2, 0);
    check_eq("t1_stall", stall, 0);
    tick();
    check_eq("t1_valid", ex_valid, 1);
    check_eq("t1_aluop", ex_aluop, 8'h25);
    check_eq("t1_alusel", ex_alusel, 3'd1);
    check_eq("t1_reg1", ex_reg1, 32'h0);
    check_eq("t1_reg2", ex_reg2, 32'h1100);
    check_eq("t1_waddr", ex_waddr_q, 5'd1);
    check_eq("t1_we", ex_we_q, 1);
    check_eq("t1_pc", ex_pc, 32'h100);

    // EX and MEM both write $1: EX wins; no-forward instance must stall
    inst = 32'h34220020; pc = 32'h104;
    ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h1100;
    mem_we = 1'b1; mem_waddr = 5'd1; mem_wdata = 32'hFFFF;
    #1;
    check_eq("t2_stall", stall, 0);
    check_eq("t2_nf_stall", stall_nf, 1);
    tick();
    check_eq("t2_reg1", ex_reg1, 32'h1100);
    check_eq("t2_reg2", ex_reg2, 32'h20);
    check_eq("t2_waddr", ex_waddr_q, 5'd2);
    check_eq("t2_nf_valid", ex_valid_nf, 0);

    // MEM-only match: forwarded by the main instance, stalls the other
    ex_we = 1'b0;
    #1;
    check_eq("t2m_nf_stall", stall_nf, 1);
    tick();
    check_eq("t2m_reg1", ex_reg1, 32'hFFFF);

    // No producer: regfile data
    mem_we = 1'b0;
    tick();
    check_eq("t2r_reg1", ex_reg1, 32'hCAFE0000);

    // Load-use on rs of or $4,$3,$5
    inst = 32'h00652025; pc = 32'h108;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h77;
    #1;
    check_eq("t3_stall", stall, 1);
    tick();
    check_eq("t3_valid", ex_valid, 0);
    check_eq("t3_cnt", stall_cnt, 16'd1);
    clear_wb();
    #1;
    check_eq("t3_stall_clr", stall, 0);
    tick();
    check_eq("t3_valid2", ex_valid, 1);
    check_eq("t3_waddr", ex_waddr_q, 5'd4);
    check_eq("t3_reg2", ex_reg2, 32'hBEEF);
    check_eq("t3_cnt2", stall_cnt, 16'd1);

    // Flush beats hold; flushed edge does not count
    flush = 1'b1; ex_stall = 1'b1;
    tick();
    check_eq("t4_valid", ex_valid, 0);
    check_eq("t4_we", ex_we_q, 0);
    check_eq("t4_cnt", stall_cnt, 16'd1);
    flush = 1'b0; ex_stall = 1'b0;
    inst = 32'h34011100; pc = 32'h10C;
    tick();
    check_eq("t4_cap", ex_valid, 1);
    ex_stall = 1'b1; inst = 32'h34220020; pc = 32'h110;
    tick();
    check_eq("t4_hold_valid", ex_valid, 1);
    check_eq("t4_hold_reg2", ex_reg2, 32'h1100);
    check_eq("t4_hold_waddr", ex_waddr_q, 5'd1);
    check_eq("t4_hold_pc", ex_pc, 32'h10C);
    check_eq("t4_cnt2", stall_cnt, 16'd2);
    ex_stall = 1'b0;

    // Decode table, no producers in flight
    for (int i = 0; i < 8; i++) begin
      inst = vecs[i].inst; pc = 32'h200 + 32'(i * 4);
      tick();
      check_eq({vecs[i].name, "_reg1"}, ex_reg1, vecs[i].reg1);
      check_eq({vecs[i].name, "_reg2"}, ex_reg2, vecs[i].reg2);
      check_eq({vecs[i].name, "_aluop"}, ex_aluop, vecs[i].aluop);
      check_eq({vecs[i].name, "_alusel"}, ex_alusel, vecs[i].alusel);
      check_eq({vecs[i].name, "_waddr"}, ex_waddr_q, vecs[i].waddr);
      check_eq({vecs[i].name, "_we"}, ex_we_q, vecs[i].we);
    end
    // Last vector was illegal: pulse now, gone next cycle
    check_eq("t5_illegal", illegal, 1);
    inst_valid = 1'b0;
    #1;
    check_eq("t5_re1_invalid", re1, 0);
    tick();
    check_eq("t5_illegal_drop", illegal, 0);
    check_eq("t5_valid", ex_valid, 0);

    // Asynchronous reset between edges
    inst = 32'h34011100; inst_valid = 1'b1;
    tick();
    check_eq("t6_pre_valid", ex_valid, 1);
    #2; rst = 1'b1; #1;
    check_eq("t6_rst_valid", ex_valid, 0);
    check_eq("t6_rst_reg2", ex_reg2, 32'h0);
    check_eq("t6_rst_cnt", stall_cnt, 16'd0);
    @(negedge clk); rst = 1'b0; inst_valid = 1'b0;

    // Saturation of the 4-bit counter
    ex_stall = 1'b1;
    repeat (20) tick();
    check_eq("t6_cnt_sat_nf", stall_cnt_nf, 4'd15);
    check_eq("t6_cnt_main", stall_cnt, 16'd20);
    ex_stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
